// File: rtl/sm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm_pkg
// Purpose  : Shared definitions for the Simple RISC Machine controller:
//            FSM state encoding and ISA opcode/op field constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sm_pkg;

  // 3-bit binary state encoding; WAIT must be zero so reset lands there.
  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_CALC   = 3'd4,
    S_WR_IMM = 3'd5,
    S_WR_REG = 3'd6
  } state_t;

  // Opcode field IR[15:13]
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // Op field IR[12:11] for the MOV opcode
  localparam logic [1:0] MOV_OP_IMM = 2'b10;
  localparam logic [1:0] MOV_OP_REG = 2'b00;

  // Op field IR[12:11] for the ALU opcode
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

endpackage : sm_pkg
`default_nettype wire

// File: rtl/instr_dec.sv
`default_nettype none
// ============================================================================
// Module   : instr_dec
// Purpose  : Combinational instruction decoder. Splits the instruction
//            register into its fields, sign-extends imm8 and classifies the
//            instruction.
// Ports    : ir_i          - latched instruction
//            rn_o/rd_o/rm_o- register number fields
//            sh_o/op_o     - shift and ALU op fields
//            sximm8_o      - sign-extended imm8
//            is_*_o        - instruction class flags (is_alu covers ADD/CMP/AND)
// Revision : 1.0 - initial release
// ============================================================================
module instr_dec
  import sm_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rm_o,
  output logic [1:0]  sh_o,
  output logic [1:0]  op_o,
  output logic [15:0] sximm8_o,
  output logic        is_mov_imm_o,
  output logic        is_mov_reg_o,
  output logic        is_alu_o,
  output logic        is_cmp_o,
  output logic        is_mvn_o,
  output logic        is_undef_o
);

  logic [2:0] w_opcode;

  assign w_opcode = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};

  assign is_mov_imm_o = (w_opcode == OP_MOV) && (op_o == MOV_OP_IMM);
  assign is_mov_reg_o = (w_opcode == OP_MOV) && (op_o == MOV_OP_REG);
  assign is_alu_o     = (w_opcode == OP_ALU) &&
                        ((op_o == ALU_ADD) || (op_o == ALU_CMP) || (op_o == ALU_AND));
  assign is_cmp_o     = (w_opcode == OP_ALU) && (op_o == ALU_CMP);
  assign is_mvn_o     = (w_opcode == OP_ALU) && (op_o == ALU_MVN);

  // Covers every other opcode plus MOV with op 01/11.
  assign is_undef_o   = ~(is_mov_imm_o | is_mov_reg_o | is_alu_o | is_mvn_o);

endmodule : instr_dec
`default_nettype wire

// File: rtl/sm_controller.sv
`default_nettype none
// ============================================================================
// Module   : sm_controller
// Purpose  : Instruction-sequencing Moore FSM for the Simple RISC Machine.
//            Latches one instruction per accepted start and steps the
//            register file / ALU controls through the required states.
// Ports    : clk, reset    - clock, synchronous active-high reset
//            s, in         - start request (WAIT only) and instruction
//            w             - ready (high in WAIT)
//            readnum, writenum, write, vsel - register file controls
//            sximm8        - sign-extended IR[7:0]
//            loada/b/c/s   - datapath load enables
//            asel          - zero the ALU A operand
//            shift, aluop  - IR[4:3], IR[12:11]
// Revision : 1.0 - initial release
// ============================================================================
module sm_controller
  import sm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic [15:0] sximm8,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic [1:0]  shift,
  output logic [1:0]  aluop
);

  state_t      state_q, state_d;
  logic [15:0] ir_q;

  logic [2:0]  w_rn, w_rd, w_rm;
  logic        w_is_mov_imm, w_is_mov_reg, w_is_alu, w_is_cmp, w_is_mvn, w_is_undef;

  instr_dec u_dec (
    .ir_i         (ir_q),
    .rn_o         (w_rn),
    .rd_o         (w_rd),
    .rm_o         (w_rm),
    .sh_o         (shift),
    .op_o         (aluop),
    .sximm8_o     (sximm8),
    .is_mov_imm_o (w_is_mov_imm),
    .is_mov_reg_o (w_is_mov_reg),
    .is_alu_o     (w_is_alu),
    .is_cmp_o     (w_is_cmp),
    .is_mvn_o     (w_is_mvn),
    .is_undef_o   (w_is_undef)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   if (s) state_d = S_DECODE;
      S_DECODE: begin
        if (w_is_undef)        state_d = S_WAIT;
        else if (w_is_mov_imm) state_d = S_WR_IMM;
        else if (w_is_alu)     state_d = S_GET_A;
        else                   state_d = S_GET_B;   // MOV reg, MVN
      end
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_CALC;
      S_CALC:   state_d = w_is_cmp ? S_WAIT : S_WR_REG;
      S_WR_IMM: state_d = S_WAIT;
      S_WR_REG: state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
  end

  // State and instruction register; IR only loads on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_WAIT) && s) ir_q <= in;
    end
  end

  // Moore output decode from state and IR only.
  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    case (state_q)
      S_WAIT:   w = 1'b1;
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      S_CALC: begin
        loadc = 1'b1;
        loads = w_is_alu;
        // MOV reg and MVN pass only the shifted B operand.
        asel  = w_is_mov_reg | w_is_mvn;
      end
      S_WR_IMM: begin
        writenum = w_rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      S_WR_REG: begin
        writenum = w_rd;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule : sm_controller
`default_nettype wire

// File: tb/tb_sm_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_controller
// Purpose  : Self-checking bench for sm_controller. A cycle-level model
//            pushes expected output bundles to a scoreboard queue as each
//            instruction is driven; every cycle one record is popped and
//            compared against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] instr;
  logic        w, write, vsel, loada, loadb, loadc, loads, asel;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm8;
  logic [1:0]  shift, aluop;

  always #5 clk = ~clk;

  sm_controller dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .in       (instr),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .sximm8   (sximm8),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .shift    (shift),
    .aluop    (aluop)
  );

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
  } outs_t;

  typedef struct {
    outs_t o;
    string tag;
  } exp_t;

  typedef struct {
    logic [15:0] ir;
    string       name;
    int          lat;    // cycles from accept to w=1
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Outputs common to every state of a given IR.
  function automatic outs_t base(input logic [15:0] ir);
    outs_t o;
    o        = '0;
    o.shift  = ir[4:3];
    o.aluop  = ir[12:11];
    o.sximm8 = {{8{ir[7]}}, ir[7:0]};
    return o;
  endfunction

  function automatic outs_t idle_zero();
    outs_t o;
    o   = '0;
    o.w = 1'b1;
    return o;
  endfunction

  task automatic push(input outs_t o, input string tag);
    exp_t e;
    e.o   = o;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Expected per-cycle outputs from DECODE up to and including the WAIT
  // cycle that follows the instruction.
  task automatic push_seq(input logic [15:0] ir, input string name);
    outs_t      b, o;
    logic [2:0] opc;
    logic [1:0] op;
    logic       alu3;
    opc  = ir[15:13];
    op   = ir[12:11];
    alu3 = (opc == 3'b101) && (op != 2'b11);
    b    = base(ir);
    push(b, {name, "/DECODE"});
    if (opc == 3'b110 && op == 2'b10) begin
      o = b; o.writenum = ir[10:8]; o.vsel = 1'b1; o.write = 1'b1;
      push(o, {name, "/WR_IMM"});
    end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
      if (alu3) begin
        o = b; o.readnum = ir[10:8]; o.loada = 1'b1;
        push(o, {name, "/GET_A"});
      end
      o = b; o.readnum = ir[2:0]; o.loadb = 1'b1;
      push(o, {name, "/GET_B"});
      o = b; o.loadc = 1'b1;
      if (alu3) o.loads = 1'b1;
      else      o.asel  = 1'b1;
      push(o, {name, "/CALC"});
      if (!(opc == 3'b101 && op == 2'b01)) begin
        o = b; o.writenum = ir[7:5]; o.write = 1'b1;
        push(o, {name, "/WR_REG"});
      end
    end
    o = b; o.w = 1'b1;
    push(o, {name, "/WAIT"});
  endtask

  task automatic check_cycle();
    outs_t act;
    exp_t  e;
    @(posedge clk);
    #1;
    act = {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, shift, aluop, sximm8};
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %h, required a queued expectation", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.o) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", e.tag, act, e.o);
      end
    end
  endtask

  task automatic check_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      push(idle_zero(), tag);
      check_cycle();
    end
  endtask

  vec_t vecs[11];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{16'hD3FE, "MOV_R3_m2",    3};
    vecs[1]  = '{16'hD57F, "MOV_R5_127",   3};
    vecs[2]  = '{16'hC0B9, "MOV_R5_R1",    5};
    vecs[3]  = '{16'hA148, "ADD_R2_R1_R0", 6};
    vecs[4]  = '{16'hA108, "ADD_R0_R1_R0", 6};
    vecs[5]  = '{16'hB265, "AND_R3_R2_R5", 6};
    vecs[6]  = '{16'hA900, "CMP_R1_R0",    5};
    vecs[7]  = '{16'hB881, "MVN_R4_R1",    5};
    vecs[8]  = '{16'h0000, "UNDEF_0000",   2};
    vecs[9]  = '{16'hE000, "UNDEF_E000",   2};
    vecs[10] = '{16'hC800, "UNDEF_C800",   2};

    reset = 1'b1;
    s     = 1'b0;
    instr = 16'h0000;
    check_idle(2, "reset_state");
    reset = 1'b0;
    check_idle(1, "post_reset_idle");

    // Single instructions: s high for exactly the accepting edge.
    foreach (vecs[k]) begin
      instr = vecs[k].ir;
      s     = 1'b1;
      push_seq(vecs[k].ir, vecs[k].name);
      check_cycle();
      s = 1'b0;
      for (int c = 1; c < vecs[k].lat; c++) check_cycle();
      if (sb.size() != 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s latency: got w=1 later than %0d cycles, required %0d",
                 vecs[k].name, vecs[k].lat, vecs[k].lat);
        sb.delete();
        check_idle(6, "resync");
      end
    end

    // Back-to-back: s held high, MOV imm then MVN accepted on first w=1 edge.
    instr = 16'hD3FE;
    s     = 1'b1;
    push_seq(16'hD3FE, "b2b_MOV");
    push_seq(16'hB881, "b2b_MVN");
    check_cycle();
    instr = 16'hB881;
    check_cycle();
    check_cycle();
    check_cycle();
    s = 1'b0;
    while (sb.size() > 0) check_cycle();

    // Reset while in GET_B of an ADD aborts it: no later write pulse.
    instr = 16'hA148;
    s     = 1'b1;
    push_seq(16'hA148, "rstmid_ADD");
    check_cycle();
    s = 1'b0;
    check_cycle();
    check_cycle();
    sb.delete();
    reset = 1'b1;
    check_idle(1, "rstmid_abort");
    reset = 1'b0;
    check_idle(4, "rstmid_no_write");

    // Reset in WR_IMM: state ends, write is 0 from the next cycle.
    instr = 16'hD3FE;
    s     = 1'b1;
    push_seq(16'hD3FE, "rstwr_MOV");
    check_cycle();
    s = 1'b0;
    check_cycle();
    sb.delete();
    reset = 1'b1;
    check_idle(1, "rstwr_abort");
    reset = 1'b0;
    check_idle(2, "rstwr_idle");

    // Reset overrides s on the same edge.
    instr = 16'hA148;
    s     = 1'b1;
    reset = 1'b1;
    check_idle(1, "rst_over_s");
    reset = 1'b0;
    s     = 1'b0;
    check_idle(1, "rst_over_s_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sm_controller
`default_nettype wire
